// File: rtl/fpga_lut_ble.sv
// rtl/fpga_lut_ble.sv - K-input basic logic element with scan-loaded LUT and optional output register
module fpga_lut_ble #(
    parameter int            K         = 4,
    parameter logic [2**K-1:0] INIT    = {{(2**K-1){1'b0}}, 1'b1},
    parameter logic          INIT_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic         cfg_en,
    input  logic         cfg_in,
    output logic         cfg_out,
    output logic         cfg_done,
    input  logic [K-1:0] lut_in,
    input  logic         ff_en,
    output logic         lut_out
);

    localparam int DEPTH    = 2**K;
    localparam int CFG_BITS = DEPTH + 1;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_BITS - 1);

    localparam logic [1:0] ST_UNCONFIG   = 2'd0;
    localparam logic [1:0] ST_LOADING    = 2'd1;
    localparam logic [1:0] ST_CONFIGURED = 2'd2;

    // chain_q = {mode, truth table}; scan-out is the mode end of the chain
    logic [CFG_BITS-1:0] chain_q, chain_d;
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q,  done_d;
    logic                ff_q,    ff_d;

    logic [DEPTH-1:0] lut_mem;
    logic             mode;
    logic             loading;

    assign lut_mem = chain_q[DEPTH-1:0];
    assign mode    = chain_q[CFG_BITS-1];
    assign loading = (state_q == ST_LOADING);

    always_comb begin
        chain_d = chain_q;
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        ff_d    = ff_q;
        // a start pulse outranks a coincident shift enable
        if (cfg_start) begin
            state_d = ST_LOADING;
            count_d = '0;
            done_d  = 1'b0;
        end else if (loading && cfg_en) begin
            chain_d = {chain_q[CFG_BITS-2:0], cfg_in};
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_BIT) begin
                state_d = ST_CONFIGURED;
                done_d  = 1'b1;
            end
        end
        if (!loading && ff_en) begin
            ff_d = lut_mem[lut_in];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= {INIT_MODE, INIT};
            state_q <= ST_UNCONFIG;
            count_q <= '0;
            done_q  <= 1'b0;
            ff_q    <= 1'b0;
        end else begin
            chain_q <= chain_d;
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            ff_q    <= ff_d;
        end
    end

    // partially shifted tables are never exposed on the output
    assign lut_out  = loading ? 1'b0 : (mode ? ff_q : lut_mem[lut_in]);
    assign cfg_out  = chain_q[CFG_BITS-1];
    assign cfg_done = done_q;

endmodule

// File: doc/fpga_lut_ble.md
Name: fpga_lut_ble

Overview:
- Parametrised K-input basic logic element (BLE) for the primitive fabric architectures.
- Contains a serially loaded LUT truth table, a mode bit, and an optional output flip-flop.
- Configured through a scan-chain port with start/enable/done signalling, then used as a configured combinational or registered logic cell.
- Default parameters power up as a fixed 4-input NOR-of-all-inputs cell: output is 1 only for input 0.

Parameters:
- K, 4, number of LUT inputs; legal range 1..6.
- INIT, {{(2**K-1){1'b0}},1'b1}, truth table loaded at reset; bit i is the output for lut_in == i.
- INIT_MODE, 0, mode bit loaded at reset; 0 = combinational output, 1 = registered output.
- Derived: CFG_BITS = 2**K + 1 (mode bit plus truth table).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cfg_start  input  1  one-cycle pulse; begins a new configuration frame.
- cfg_en  input  1  shift enable; one config bit accepted per cycle while loading.
- cfg_in  input  1  serial config data.
- cfg_out  output  1  chain MSB (scan-out, for chaining BLEs and readback).
- cfg_done  output  1  high when a complete frame has been loaded.
- lut_in  input  K  LUT select inputs.
- ff_en  input  1  clock enable for the output flip-flop.
- lut_out  output  1  BLE output.

Behaviour:
- Chain = {mode, lut_mem[2**K-1:0]}, CFG_BITS wide.
- Shift operation: chain <= {chain[CFG_BITS-2:0], cfg_in}; cfg_out = chain[CFG_BITS-1].
- Frame order on cfg_in: mode bit first, then truth table MSB-first (entry 2**K-1 down to 0).
- States: UNCONFIG, LOADING, CONFIGURED. Bit counter width is clog2(CFG_BITS+1).
- Reset (rst_n low at edge):
  - lut_mem=INIT, mode=INIT_MODE, state=UNCONFIG, count=0.
  - ff_q=0, cfg_done=0, hence cfg_out=INIT_MODE.
  - Reset applies from any state, including mid-load.
- cfg_start, any state: next state LOADING, count=0, cfg_done=0. No shift that cycle, even if cfg_en is also high (start wins).
- LOADING with cfg_en=1:
  - Shift one bit and increment count.
  - On the shift where count==CFG_BITS-1, next state is CONFIGURED and cfg_done=1 from the following cycle.
  - Total latency: cfg_done is high the cycle after the CFG_BITS-th accepted bit.
- LOADING with cfg_en=0: hold the chain and count. There is no timeout.
- cfg_en in UNCONFIG or CONFIGURED: ignored; no shift, no count change.
- cfg_start mid-load: restarts the count. Chain contents are undefined until the new frame completes. Output gating covers this window.
- Output, state != LOADING:
  - mode=0: lut_out = lut_mem[lut_in], combinational, same cycle.
  - mode=1: lut_out = ff_q.
  - ff_q <= lut_mem[lut_in] on each edge with ff_en=1, one-cycle latency. ff_en=0 holds ff_q.
- Output, state == LOADING: lut_out forced to 0 and ff_q held, regardless of ff_en.
- cfg_done stays high until the next cfg_start or reset.
- lut_in index is always in range, since the table is 2**K deep. No X propagation from an out-of-range index.

Test Plan:
- Reset, K=4, default INIT: lut_in=0 -> lut_out=1; lut_in=4'h5 -> lut_out=0; cfg_done=0, cfg_out=0.
- Load 4-input AND:
  - Stimulus: cfg_start, then 17 cfg_en cycles carrying mode=0 followed by 16'h8000 MSB-first.
  - lut_out=0 throughout the load.
  - cfg_done rises the cycle after the 17th bit.
  - Afterwards: lut_in=F -> 1, lut_in=E -> 0.
- Registered mode:
  - Stimulus: load mode=1 with table 16'h6996 (parity), ff_en=1.
  - lut_in=3 -> lut_out=0 after the next edge; lut_in=1 -> lut_out=1 one edge later.
  - Drop ff_en, change lut_in=7 -> lut_out holds 1.
- Restart and collision:
  - cfg_start after 8 bits, then cfg_start+cfg_en in the same cycle -> no shift.
  - cfg_done rises only after 17 further accepted bits.
  - cfg_en pulses after CONFIGURED leave the table unchanged; cfg_out still equals the loaded mode bit.
- Reset mid-load: rst_n low for one cycle after 10 bits -> state UNCONFIG, cfg_done=0, lut_out back to INIT behaviour (lut_in=0 -> 1).
- Parameter sweep K=1 and K=6: CFG_BITS=3 and 65 respectively; full load of a random table followed by an exhaustive lut_in check matches the loaded table.
